chip_bus_cycle: RTL and testbench

// - Runs CPU accesses to Agnus chip RAM/register space after the address decoder flags nRAMSPACE/nREGSPACE.
// - Waits for a free chip-bus slot (DBR low), aligns to CLK7 and drives chip-bus strobes.
// - Pulses TACK to the transfer-ack stage, which returns DSACK to the CPU. Sits downstream of address decode.

---
 rtl/chip_bus_cycle_if.sv | 27 ++
 rtl/chip_bus_cycle.sv | 147 ++++++++++++++
 tb/tb_chip_bus_cycle.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/chip_bus_cycle_if.sv
// CPU-side request and chip-bus strobe signals between the decoder/CPU side and chip_bus_cycle.
// Spec signal names are kept so the bus reads like the board schematic.
interface chip_bus_cycle_if;
  logic CLK7;
  logic nTS;
  logic RnW;
  logic nRAMSPACE;
  logic nREGSPACE;
  logic DBR;
  logic nCHIP_AS;
  logic nCHIP_DS;
  logic CHIP_RnW;
  logic DRDLE;
  logic TACK;
  logic BUSY;
  logic nBERR;

  modport master (
    output CLK7, nTS, RnW, nRAMSPACE, nREGSPACE, DBR,
    input  nCHIP_AS, nCHIP_DS, CHIP_RnW, DRDLE, TACK, BUSY, nBERR
  );

  modport slave (
    input  CLK7, nTS, RnW, nRAMSPACE, nREGSPACE, DBR,
    output nCHIP_AS, nCHIP_DS, CHIP_RnW, DRDLE, TACK, BUSY, nBERR
  );
endinterface

// File: rtl/chip_bus_cycle.sv
// Chip RAM/register bus cycle: waits for a free DMA slot, drives AS/DS aligned to CLK7, pulses TACK.
// Latency: 3-clk CLK7 sync + STROBE_EDGES CLK7 periods + 1 clk; one extra request may queue as pending.
// Optional CHIP_TIMEOUT_EN: WAIT_SLOT gives up after TIMEOUT clocks with a one-cycle nBERR pulse.
module chip_bus_cycle #(
  parameter int STROBE_EDGES = 2,
  parameter int RECOVER_CLKS = 2,
  parameter int TIMEOUT      = 255
) (
  input logic              CLK40,
  input logic              nRESET,
  chip_bus_cycle_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, WAIT_SLOT, STROBE, ACK, RECOVER} state_t;

  localparam logic [2:0] STR_LAST = 3'(STROBE_EDGES - 1);
  localparam logic [3:0] REC_LAST = 4'(RECOVER_CLKS - 1);

  state_t     state_q, state_nxt;
  logic       c7_s1, c7_s2, c7_s3, c7_rise;
  logic       pending_q, pending_rnw_q;
  logic [2:0] str_cnt_q;
  logic [3:0] rec_cnt_q;
  logic       as_n_q, ds_n_q, rnw_q, drdle_q, tack_q, busy_q;
  logic       as_n_nxt, ds_n_nxt, drdle_nxt, tack_nxt, busy_nxt, strobing_nxt;
  logic       start, timeout_hit;

  assign start = !bus.nTS && (!bus.nRAMSPACE || !bus.nREGSPACE);

`ifdef CHIP_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] to_cnt_q;
  logic       berr_n_q;

  assign timeout_hit = (to_cnt_q == TO_LAST);

  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      to_cnt_q <= 8'd0;
      berr_n_q <= 1'b1;
    end else begin
      if (state_q != WAIT_SLOT)
        to_cnt_q <= 8'd0;
      else if (to_cnt_q != 8'hff)
        to_cnt_q <= to_cnt_q + 8'd1;
      // Leaving WAIT_SLOT straight to IDLE only happens on timeout.
      berr_n_q <= !(state_q == WAIT_SLOT && state_nxt == IDLE);
    end
  end

  assign bus.nBERR = berr_n_q;
`else
  assign timeout_hit = 1'b0;
  assign bus.nBERR   = 1'b1;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:      if (pending_q || start) state_nxt = WAIT_SLOT;
      // DBR has priority over a coincident CLK7 edge.
      WAIT_SLOT: if (c7_rise && !bus.DBR) state_nxt = STROBE;
                 else if (timeout_hit)    state_nxt = IDLE;
      STROBE:    if (c7_rise && str_cnt_q == STR_LAST) state_nxt = ACK;
      ACK:       state_nxt = RECOVER;
      RECOVER:   if (rec_cnt_q == REC_LAST) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase

    strobing_nxt = (state_nxt == STROBE) || (state_nxt == ACK);
    as_n_nxt     = !strobing_nxt;
    // Writes hold off DS one clock so data is stable before the strobe.
    ds_n_nxt     = !(strobing_nxt && (rnw_q || state_q == STROBE || state_q == ACK));
    tack_nxt     = (state_nxt == ACK);
    drdle_nxt    = tack_nxt && rnw_q;
    busy_nxt     = (state_nxt != IDLE);
  end

  always_ff @(posedge CLK40) begin
    if (!nRESET) begin
      state_q       <= IDLE;
      c7_s1         <= 1'b0;
      c7_s2         <= 1'b0;
      c7_s3         <= 1'b0;
      c7_rise       <= 1'b0;
      pending_q     <= 1'b0;
      pending_rnw_q <= 1'b1;
      str_cnt_q     <= 3'd0;
      rec_cnt_q     <= 4'd0;
      rnw_q         <= 1'b1;
      as_n_q        <= 1'b1;
      ds_n_q        <= 1'b1;
      drdle_q       <= 1'b0;
      tack_q        <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q <= state_nxt;
      c7_s1   <= bus.CLK7;
      c7_s2   <= c7_s1;
      c7_s3   <= c7_s2;
      c7_rise <= c7_s2 && !c7_s3;

      if (state_q == IDLE && pending_q) begin
        rnw_q         <= pending_rnw_q;
        pending_q     <= start;
        pending_rnw_q <= bus.RnW;
      end else if (state_q == IDLE) begin
        if (start) rnw_q <= bus.RnW;
      end else if (start) begin
        pending_q     <= 1'b1;
        pending_rnw_q <= bus.RnW;
      end

      if (state_q != STROBE)
        str_cnt_q <= 3'd0;
      else if (c7_rise && str_cnt_q != 3'd7)
        str_cnt_q <= str_cnt_q + 3'd1;

      if (state_q != RECOVER)
        rec_cnt_q <= 4'd0;
      else if (rec_cnt_q != 4'd15)
        rec_cnt_q <= rec_cnt_q + 4'd1;

      as_n_q  <= as_n_nxt;
      ds_n_q  <= ds_n_nxt;
      drdle_q <= drdle_nxt;
      tack_q  <= tack_nxt;
      busy_q  <= busy_nxt;
    end
  end

  assign bus.nCHIP_AS = as_n_q;
  assign bus.nCHIP_DS = ds_n_q;
  assign bus.CHIP_RnW = rnw_q;
  assign bus.DRDLE    = drdle_q;
  assign bus.TACK     = tack_q;
  assign bus.BUSY     = busy_q;

  a_param_range: assert property (@(posedge CLK40)
    (STROBE_EDGES >= 1 && STROBE_EDGES <= 7) && (RECOVER_CLKS >= 1 && RECOVER_CLKS <= 15) &&
    (TIMEOUT >= 1 && TIMEOUT <= 255));

  // Only one queued request is held; a third overlapping start loses the older one.
  a_single_pending: assert property (@(posedge CLK40) disable iff (!nRESET)
    !(start && pending_q && state_q != IDLE));

endmodule

// File: tb/tb_chip_bus_cycle.sv
// Bench for chip_bus_cycle: per-cycle vector table for read/write/ignored accesses,
// then free-running CLK7 sequences for DBR arbitration, back-to-back, reset and timeout.
module tb_chip_bus_cycle;

  logic clk40;
  logic nreset;
  chip_bus_cycle_if bus();

  chip_bus_cycle #(.STROBE_EDGES(2), .RECOVER_CLKS(2), .TIMEOUT(16)) dut (
    .CLK40  (clk40),
    .nRESET (nreset),
    .bus    (bus)
  );

  initial clk40 = 1'b0;
  always #5 clk40 = ~clk40;

  // in  = {nRESET, CLK7, nTS, RnW, nRAMSPACE, nREGSPACE, DBR}
  // exp = {nCHIP_AS, nCHIP_DS, CHIP_RnW, DRDLE, TACK, BUSY, nBERR}
  typedef struct {
    int         cyc;
    logic [6:0] in;
    logic [6:0] ex;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   ph = 3;
  int   tack_cnt = 0;
  int   berr_cnt = 0;
  int   as_cnt = 0;

  function automatic logic [6:0] outs();
    return {bus.nCHIP_AS, bus.nCHIP_DS, bus.CHIP_RnW, bus.DRDLE, bus.TACK, bus.BUSY, bus.nBERR};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic add(input int c, input logic [6:0] in, input logic [6:0] ex);
    vec_t v;
    v.cyc = c;
    v.in  = in;
    v.ex  = ex;
    tbl.push_back(v);
  endtask

  task automatic cyc();
    @(posedge clk40);
    #2;
  endtask

  // CLK7 period is 6 clocks: low for phases 0..2, high for 3..5.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bus.CLK7 = (ph >= 3);
      ph = (ph == 5) ? 0 : ph + 1;
      cyc();
      if (bus.TACK)      tack_cnt++;
      if (!bus.nBERR)    berr_cnt++;
      if (!bus.nCHIP_AS) as_cnt++;
    end
  endtask

  task automatic align(input int p);
    while (ph != p) run(1);
  endtask

  task automatic start(input logic rnw, input logic ram_n, input logic reg_n);
    bus.nTS = 1'b0;
    bus.RnW = rnw;
    bus.nRAMSPACE = ram_n;
    bus.nREGSPACE = reg_n;
    run(1);
    bus.nTS = 1'b1;
    bus.RnW = 1'b1;
    bus.nRAMSPACE = 1'b1;
    bus.nREGSPACE = 1'b1;
  endtask

  task automatic wait_tack(input int budget, input string name);
    int k = 0;
    while (!bus.TACK && k < budget) begin
      run(1);
      k++;
    end
    check(name, {6'd0, bus.TACK}, 7'd1);
  endtask

  task automatic wait_as(input int budget, input string name);
    int k = 0;
    while (bus.nCHIP_AS && k < budget) begin
      run(1);
      k++;
    end
    check(name, {6'd0, bus.nCHIP_AS}, 7'd0);
  endtask

  initial begin
    nreset = 1'b0;
    bus.CLK7 = 1'b0;
    bus.nTS = 1'b1;
    bus.RnW = 1'b1;
    bus.nRAMSPACE = 1'b1;
    bus.nREGSPACE = 1'b1;
    bus.DBR = 1'b0;

    // Read from chip RAM: strobes fall together, TACK+DRDLE after two more CLK7 rises.
    add(3, 7'b0011110, 7'b1110001);
    add(2, 7'b1011110, 7'b1110001);
    add(1, 7'b1001010, 7'b1110011);
    add(2, 7'b1011110, 7'b1110011);
    add(3, 7'b1111110, 7'b1110011);
    add(1, 7'b1111110, 7'b0010011);
    add(2, 7'b1011110, 7'b0010011);
    add(3, 7'b1111110, 7'b0010011);
    add(1, 7'b1111110, 7'b0010011);
    add(2, 7'b1011110, 7'b0010011);
    add(3, 7'b1111110, 7'b0010011);
    add(1, 7'b1111110, 7'b0011111);
    add(1, 7'b1111110, 7'b1110011);
    add(1, 7'b1111110, 7'b1110011);
    add(1, 7'b1111110, 7'b1110001);
    // Write to registers: DS one clock after AS, no DRDLE.
    add(1, 7'b1100100, 7'b1100011);
    add(2, 7'b1011110, 7'b1100011);
    add(3, 7'b1111110, 7'b1100011);
    add(1, 7'b1111110, 7'b0100011);
    add(1, 7'b1011110, 7'b0000011);
    add(1, 7'b1011110, 7'b0000011);
    add(3, 7'b1111110, 7'b0000011);
    add(1, 7'b1111110, 7'b0000011);
    add(2, 7'b1011110, 7'b0000011);
    add(3, 7'b1111110, 7'b0000011);
    add(1, 7'b1111110, 7'b0000111);
    add(2, 7'b1111110, 7'b1100011);
    add(1, 7'b1111110, 7'b1100001);
    // nTS with neither space selected is ignored.
    add(1, 7'b1101110, 7'b1100001);
    add(3, 7'b1111110, 7'b1100001);

    for (int i = 0; i < tbl.size(); i++) begin
      {nreset, bus.CLK7, bus.nTS, bus.RnW, bus.nRAMSPACE, bus.nREGSPACE, bus.DBR} = tbl[i].in;
      repeat (tbl[i].cyc) cyc();
      check($sformatf("vec%0d", i), outs(), tbl[i].ex);
    end
    bus.nTS = 1'b1;
    bus.RnW = 1'b1;
    bus.nRAMSPACE = 1'b1;
    bus.nREGSPACE = 1'b1;
    ph = 3;

    // DBR busy for 40 CLK7 periods, then released just after a CLK7 edge was consumed.
    tack_cnt = 0;
    as_cnt = 0;
    bus.DBR = 1'b1;
    start(1'b1, 1'b0, 1'b1);
    run(240);
    check("dbr_hold_no_strobe", 7'(as_cnt), 7'd0);
    check("dbr_hold_busy", {6'd0, bus.BUSY}, 7'd1);
    align(1);
    bus.DBR = 1'b0;
    run(5);
    check("dbr_fall_wait", {6'd0, bus.nCHIP_AS}, 7'd1);
    run(1);
    check("dbr_fall_strobe", {6'd0, bus.nCHIP_AS}, 7'd0);
    run(80);
    check("dbr_tack_once", 7'(tack_cnt), 7'd1);

    // DBR rising together with c7_rise wins; DBR during STROBE is ignored.
    align(1);
    start(1'b1, 1'b0, 1'b1);
    run(4);
    bus.DBR = 1'b1;
    run(1);
    check("dbr_wins_tie", {6'd0, bus.nCHIP_AS}, 7'd1);
    bus.DBR = 1'b0;
    run(6);
    check("slot_after_tie", {6'd0, bus.nCHIP_AS}, 7'd0);
    tack_cnt = 0;
    bus.DBR = 1'b1;
    run(40);
    check("dbr_in_strobe_ignored", 7'(tack_cnt), 7'd1);
    bus.DBR = 1'b0;
    run(20);

    // Back-to-back: second start lands in RECOVER and runs after IDLE re-entry.
    tack_cnt = 0;
    start(1'b1, 1'b0, 1'b1);
    wait_tack(80, "b2b_first_tack");
    run(1);
    start(1'b0, 1'b1, 1'b0);
    run(100);
    check("b2b_tack_count", 7'(tack_cnt), 7'd2);
    check("b2b_second_rnw", {6'd0, bus.CHIP_RnW}, 7'd0);
    check("b2b_idle", {6'd0, bus.BUSY}, 7'd0);

    // Reset for one edge in the middle of STROBE.
    tack_cnt = 0;
    start(1'b1, 1'b0, 1'b1);
    wait_as(40, "rst_reach_strobe");
    run(2);
    nreset = 1'b0;
    run(1);
    check("rst_mid_outs", outs(), 7'b1110001);
    nreset = 1'b1;
    run(60);
    check("rst_no_tack", 7'(tack_cnt), 7'd0);
    start(1'b0, 1'b0, 1'b1);
    run(60);
    check("rst_new_access", 7'(tack_cnt), 7'd1);

`ifdef CHIP_TIMEOUT_EN
    tack_cnt = 0;
    bus.DBR = 1'b1;
    start(1'b1, 1'b0, 1'b1);
    run(15);
    check("to_before", {5'd0, bus.BUSY, bus.nBERR}, 7'b0000011);
    run(1);
    check("to_berr", {4'd0, bus.nBERR, bus.BUSY, bus.TACK}, 7'b0000000);
    run(1);
    check("to_berr_one", {6'd0, bus.nBERR}, 7'd1);
    check("to_no_tack", 7'(tack_cnt), 7'd0);
    bus.DBR = 1'b0;
    run(10);
`else
    tack_cnt = 0;
    berr_cnt = 0;
    bus.DBR = 1'b1;
    start(1'b1, 1'b0, 1'b1);
    run(300);
    check("nto_no_berr", 7'(berr_cnt), 7'd0);
    check("nto_still_busy", {6'd0, bus.BUSY}, 7'd1);
    bus.DBR = 1'b0;
    run(60);
    check("nto_tack", 7'(tack_cnt), 7'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
